button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 145 ++++++++++++++
 tb/tb_button_event_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Five independent press / release / long-press / auto-repeat decoders for debounced buttons.
// Every event output is a registered one-cycle pulse that follows the sampled level change by one clock.
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 12500000,
    parameter int unsigned REPEAT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] levels,
    output logic [4:0] press,
    output logic [4:0] release_evt,
    output logic [4:0] long_press,
    output logic [4:0] repeat_evt,
    output logic [4:0] held
);

    localparam int NUM_BUTTONS = 5;
    localparam int CW          = 25;

    localparam logic [CW-1:0] LONG_TERM   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TERM = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state_q [NUM_BUTTONS];
    state_t          state_d [NUM_BUTTONS];
    logic [CW-1:0]   cnt_q   [NUM_BUTTONS];
    logic [CW-1:0]   cnt_d   [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] long_hit;
    logic [NUM_BUTTONS-1:0] repeat_hit;

    logic [NUM_BUTTONS-1:0] press_q,       press_d;
    logic [NUM_BUTTONS-1:0] release_evt_q, release_evt_d;
    logic [NUM_BUTTONS-1:0] long_press_q,  long_press_d;
    logic [NUM_BUTTONS-1:0] repeat_evt_q,  repeat_evt_d;
    logic [NUM_BUTTONS-1:0] held_q,        held_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Terminal counts only count while the button is still down, so a release on that sample wins.
    always_comb begin
        long_hit   = '0;
        repeat_hit = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            long_hit[i]   = (state_q[i] == PRESSED) && levels[i] && (cnt_q[i] == LONG_TERM);
            repeat_hit[i] = (state_q[i] == HOLD)    && levels[i] && (cnt_q[i] == REPEAT_TERM);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (levels[i]) begin
                        state_d[i] = PRESSED;
                    end
                end
                PRESSED: begin
                    if (!levels[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (long_hit[i]) begin
                        state_d[i] = HOLD;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                HOLD: begin
                    if (!levels[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (repeat_hit[i]) begin
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        press_d       = '0;
        release_evt_d = '0;
        long_press_d  = '0;
        repeat_evt_d  = '0;
        held_d        = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            press_d[i]       = (state_q[i] == IDLE) && levels[i];
            release_evt_d[i] = ((state_q[i] == PRESSED) || (state_q[i] == HOLD)) && !levels[i];
            long_press_d[i]  = long_hit[i];
            repeat_evt_d[i]  = repeat_hit[i];
            held_d[i]        = (state_d[i] != IDLE);
        end
    end

    // Registering held from the next state lines its edges up with the press and release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q       <= '0;
            release_evt_q <= '0;
            long_press_q  <= '0;
            repeat_evt_q  <= '0;
            held_q        <= '0;
        end else begin
            press_q       <= press_d;
            release_evt_q <= release_evt_d;
            long_press_q  <= long_press_d;
            repeat_evt_q  <= repeat_evt_d;
            held_q        <= held_d;
        end
    end

    assign press       = press_q;
    assign release_evt = release_evt_q;
    assign long_press  = long_press_q;
    assign repeat_evt  = repeat_evt_q;
    assign held        = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and random bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=3.
// Expected outputs come from an age-since-press model queued per driven sample.
module tb_button_event_decoder;

   localparam int L = 8;
   localparam int R = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] levels = 5'b0;
   logic [4:0] press, release_evt, long_press, repeat_evt, held;

   typedef struct packed {
      logic [4:0] press;
      logic [4:0] rel;
      logic [4:0] lp;
      logic [4:0] rp;
      logic [4:0] held;
   } exp_t;

   exp_t sb_q[$];
   bit   active [5];
   int   age [5];
   int   vectors = 0;
   int   miscompares = 0;
   int   obs_press [5];
   int   obs_rel [5];
   int   obs_long [5];
   int   obs_rep [5];

   button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .levels(levels),
      .press(press),
      .release_evt(release_evt),
      .long_press(long_press),
      .repeat_evt(repeat_evt),
      .held(held)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s t=%0t observed=%b expected=%b", tag, $time, observed, expected);
      end
   endtask

   task automatic clearCounts();
      for (int i = 0; i < 5; i++) begin
         obs_press[i] = 0;
         obs_rel[i]   = 0;
         obs_long[i]  = 0;
         obs_rep[i]   = 0;
      end
   endtask

   task automatic modelReset();
      sb_q.delete();
      for (int i = 0; i < 5; i++) begin
         active[i] = 1'b0;
         age[i]    = 0;
      end
   endtask

   // Event times follow from the age since press: long at age L, repeats at L + k*R.
   task automatic modelStep(input logic [4:0] lv, output exp_t e);
      e = '0;
      for (int i = 0; i < 5; i++) begin
         if (!active[i]) begin
            if (lv[i]) begin
               e.press[i] = 1'b1;
               active[i]  = 1'b1;
               age[i]     = 0;
            end
         end else if (!lv[i]) begin
            e.rel[i]  = 1'b1;
            active[i] = 1'b0;
         end else begin
            age[i]++;
            if (age[i] == L) e.lp[i] = 1'b1;
            else if (age[i] > L && ((age[i] - L) % R) == 0) e.rp[i] = 1'b1;
         end
         e.held[i] = active[i];
      end
   endtask

   task automatic checkZero(input string tag);
      checkOutput({tag, "_press"}, press, 5'b0);
      checkOutput({tag, "_release"}, release_evt, 5'b0);
      checkOutput({tag, "_long"}, long_press, 5'b0);
      checkOutput({tag, "_repeat"}, repeat_evt, 5'b0);
      checkOutput({tag, "_held"}, held, 5'b0);
   endtask

   task automatic applyStimulus(input logic [4:0] lv);
      exp_t e;
      exp_t got;
      logic ok;
      levels = lv;
      modelStep(lv, e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      checkOutput("press", press, got.press);
      checkOutput("release", release_evt, got.rel);
      checkOutput("long_press", long_press, got.lp);
      checkOutput("repeat", repeat_evt, got.rp);
      checkOutput("held", held, got.held);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!$onehot0({press[i], release_evt[i], long_press[i], repeat_evt[i]})) ok = 1'b0;
         obs_press[i] += int'(press[i]);
         obs_rel[i]   += int'(release_evt[i]);
         obs_long[i]  += int'(long_press[i]);
         obs_rep[i]   += int'(repeat_evt[i]);
      end
      checkOutput("exclusive", {4'b0, ok}, 5'b00001);
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] lv;
      logic [4:0] mask;

      modelReset();
      clearCounts();
      @(posedge clk);
      #1;
      checkZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(5'b00000);
      applyStimulus(5'b00000);

      for (int k = 0; k < 5; k++) applyStimulus(5'b00001);
      applyStimulus(5'b00000);
      applyStimulus(5'b00000);

      clearCounts();
      for (int k = 0; k < 20; k++) applyStimulus(5'b00100);
      applyStimulus(5'b00000);
      applyStimulus(5'b00000);
      checkOutput("long2_count", 5'(obs_long[2]), 5'd1);
      checkOutput("repeat2_count", 5'(obs_rep[2]), 5'd3);
      checkOutput("release2_count", 5'(obs_rel[2]), 5'd1);

      clearCounts();
      for (int k = 0; k < L; k++) applyStimulus(5'b00010);
      applyStimulus(5'b00000);
      applyStimulus(5'b00000);
      checkOutput("long1_race", 5'(obs_long[1]), 5'd0);
      checkOutput("release1_race", 5'(obs_rel[1]), 5'd1);

      clearCounts();
      for (int k = 0; k < 4; k++) applyStimulus(5'b11111);
      for (int k = 0; k < 6; k++) applyStimulus(5'b10111);
      applyStimulus(5'b00000);
      applyStimulus(5'b00000);
      mask = '0;
      for (int i = 0; i < 5; i++) mask[i] = (obs_long[i] == 1);
      checkOutput("long_mask", mask, 5'b10111);

      for (int k = 0; k < 12; k++) applyStimulus(5'b10000);
      clearCounts();
      rst_n = 1'b0;
      #1;
      checkZero("async_reset");
      modelReset();
      @(posedge clk);
      #1;
      checkZero("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(5'b10000);
      applyStimulus(5'b10000);
      checkOutput("press4_after_reset", 5'(obs_press[4]), 5'd1);
      checkOutput("release4_after_reset", 5'(obs_rel[4]), 5'd0);
      applyStimulus(5'b00000);
      applyStimulus(5'b00000);

      clearCounts();
      lv = 5'b0;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 15) == 0) lv[i] = ~lv[i];
         end
         applyStimulus(lv);
      end
      for (int i = 0; i < 5; i++) begin
         checkOutput("balance", 5'(obs_press[i] - obs_rel[i]), {4'b0, active[i]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
